// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline sequencing controller for the 5-stage, 8-register core.
//            Handles load-use stalls, taken branch/jump flushes and slow
//            data-memory handshakes in MEM. Outputs are Mealy so a stall
//            takes effect in the cycle the hazard is seen.
// Options  : HAZARD_PERF_CNT_EN adds stallCnt/flushCnt performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memReadEX,
    input  logic [2:0]  rdEX,
    input  logic [2:0]  r1ID,
    input  logic [2:0]  r2ID,
    input  logic        useR1ID,
    input  logic        useR2ID,
    input  logic        branchTakenEX,
    input  logic        memReqMEM,
    input  logic        memReadyMEM,
    output logic        pcWrite,
    output logic        ifidWrite,
    output logic        ifidFlush,
    output logic        idexFlush,
    output logic        exmemWrite,
    output logic        memwbBubble,
    output logic [1:0]  state,
    output logic        memErr
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0] stallCnt,
    output logic [15:0] flushCnt
`endif
);

    localparam logic [1:0] c_RUN       = 2'b00;
    localparam logic [1:0] c_LOADSTALL = 2'b01;
    localparam logic [1:0] c_MEMWAIT   = 2'b10;

    localparam logic [2:0] c_STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [7:0] c_TIMEOUT    = 8'(MEM_TIMEOUT);

    logic [1:0] r_state;
    logic [2:0] r_stallCnt;
    logic [7:0] r_toCnt;
    logic       r_memErr;

    logic [1:0] w_nextState;
    logic [2:0] w_nextStallCnt;
    logic [7:0] w_nextToCnt;
    logic       w_setErr;
    logic       w_branchFlush;
    logic       w_luh;
    logic       w_memWait;

    logic       w_pcWrite;
    logic       w_ifidWrite;
    logic       w_ifidFlush;
    logic       w_idexFlush;
    logic       w_exmemWrite;
    logic       w_memwbBubble;

    // Load-use hazard: EX load writes a register the ID instruction reads (r0 never hazards)
    assign w_luh = memReadEX && (rdEX != 3'd0) &&
                   ((useR1ID && (r1ID == rdEX)) || (useR2ID && (r2ID == rdEX)));

    assign w_memWait = memReqMEM && !memReadyMEM;

    // Next-state and Mealy output decode, highest-priority event wins
    always_comb begin
        w_nextState    = r_state;
        w_nextStallCnt = r_stallCnt;
        w_nextToCnt    = r_toCnt;
        w_setErr       = 1'b0;
        w_branchFlush  = 1'b0;
        w_pcWrite      = 1'b1;
        w_ifidWrite    = 1'b1;
        w_ifidFlush    = 1'b0;
        w_idexFlush    = 1'b0;
        w_exmemWrite   = 1'b1;
        w_memwbBubble  = 1'b0;

        case (r_state)
            c_RUN, c_LOADSTALL: begin
                if (w_memWait) begin
                    // Freeze everything; the load-use hazard (if any) is re-detected
                    // after release because ID/EX holds its contents.
                    w_pcWrite      = 1'b0;
                    w_ifidWrite    = 1'b0;
                    w_exmemWrite   = 1'b0;
                    w_memwbBubble  = 1'b1;
                    w_nextState    = c_MEMWAIT;
                    w_nextToCnt    = 8'd1;
                    w_nextStallCnt = 3'd0;
                end else if (branchTakenEX) begin
                    w_ifidFlush    = 1'b1;
                    w_idexFlush    = 1'b1;
                    w_branchFlush  = 1'b1;
                    w_nextState    = c_RUN;
                    w_nextStallCnt = 3'd0;
                end else if (w_luh || (r_state == c_LOADSTALL)) begin
                    w_pcWrite   = 1'b0;
                    w_ifidWrite = 1'b0;
                    w_idexFlush = 1'b1;
                    if (r_state == c_RUN) begin
                        if (LOAD_STALL_CYCLES <= 1) begin
                            w_nextState    = c_RUN;
                            w_nextStallCnt = 3'd0;
                        end else begin
                            w_nextState    = c_LOADSTALL;
                            w_nextStallCnt = c_STALL_INIT;
                        end
                    end else if (r_stallCnt <= 3'd1) begin
                        // Last bubble of this hazard
                        w_nextState    = c_RUN;
                        w_nextStallCnt = 3'd0;
                    end else begin
                        w_nextStallCnt = r_stallCnt - 3'd1;
                    end
                end
            end

            c_MEMWAIT: begin
                if (memReadyMEM) begin
                    w_nextState = c_RUN;
                    w_nextToCnt = 8'd0;
                end else if (r_toCnt >= c_TIMEOUT) begin
                    // Give up on the access and flag it; pipeline resumes
                    w_setErr    = 1'b1;
                    w_nextState = c_RUN;
                    w_nextToCnt = 8'd0;
                end else begin
                    w_pcWrite     = 1'b0;
                    w_ifidWrite   = 1'b0;
                    w_exmemWrite  = 1'b0;
                    w_memwbBubble = 1'b1;
                    if (r_toCnt != 8'hFF) begin
                        w_nextToCnt = r_toCnt + 8'd1;
                    end
                end
            end

            default: begin
                w_nextState    = c_RUN;
                w_nextStallCnt = 3'd0;
                w_nextToCnt    = 8'd0;
            end
        endcase
    end

    // State, counters and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_RUN;
            r_stallCnt <= 3'd0;
            r_toCnt    <= 8'd0;
            r_memErr   <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_stallCnt <= w_nextStallCnt;
            r_toCnt    <= w_nextToCnt;
            if (w_setErr) begin
                r_memErr <= 1'b1;
            end
        end
    end

    // While reset is held the pipeline is frozen and filled with NOPs
    assign pcWrite     = rst & w_pcWrite;
    assign ifidWrite   = rst & w_ifidWrite;
    assign exmemWrite  = rst & w_exmemWrite;
    assign ifidFlush   = ~rst | w_ifidFlush;
    assign idexFlush   = ~rst | w_idexFlush;
    assign memwbBubble = ~rst | w_memwbBubble;
    assign state       = r_state;
    assign memErr      = r_memErr;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] r_stallCnt16;
    logic [15:0] r_flushCnt16;

    // Saturating counts of PC-stalled cycles and branch flushes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stallCnt16 <= 16'd0;
            r_flushCnt16 <= 16'd0;
        end else begin
            if (!w_pcWrite && (r_stallCnt16 != 16'hFFFF)) begin
                r_stallCnt16 <= r_stallCnt16 + 16'd1;
            end
            if (w_branchFlush && (r_flushCnt16 != 16'hFFFF)) begin
                r_flushCnt16 <= r_flushCnt16 + 16'd1;
            end
        end
    end

    assign stallCnt = r_stallCnt16;
    assign flushCnt = r_flushCnt16;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Scoreboard bench for hazard_ctrl. Instance A uses default
//            parameters, instance B uses LOAD_STALL_CYCLES=3. Each cycle the
//            stimulus pushes hand-computed expectations; a monitor pops and
//            compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    // Output vector order: {pcWrite, ifidWrite, ifidFlush, idexFlush, exmemWrite, memwbBubble}
    localparam logic [5:0] c_DEF    = 6'b110010;
    localparam logic [5:0] c_STALL  = 6'b000110;
    localparam logic [5:0] c_FLUSH  = 6'b111110;
    localparam logic [5:0] c_FREEZE = 6'b000001;
    localparam logic [5:0] c_RST    = 6'b001101;

    typedef struct packed {
        logic [1:0] stA;
        logic [5:0] oA;
        logic [1:0] stB;
        logic [5:0] oB;
        logic       err;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       memReadEX = 1'b0;
    logic [2:0] rdEX = 3'd0;
    logic [2:0] r1ID = 3'd0;
    logic [2:0] r2ID = 3'd0;
    logic       useR1ID = 1'b0;
    logic       useR2ID = 1'b0;
    logic       branchTakenEX = 1'b0;
    logic       memReqMEM = 1'b0;
    logic       memReadyMEM = 1'b0;

    logic       pcWriteA, ifidWriteA, ifidFlushA, idexFlushA, exmemWriteA, memwbBubbleA, memErrA;
    logic [1:0] stateA;
    logic       pcWriteB, ifidWriteB, ifidFlushB, idexFlushB, exmemWriteB, memwbBubbleB, memErrB;
    logic [1:0] stateB;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cycNo      = 0;

    always #5 clk = ~clk;

    hazard_ctrl dutA (
        .clk(clk), .rst(rst),
        .memReadEX(memReadEX), .rdEX(rdEX), .r1ID(r1ID), .r2ID(r2ID),
        .useR1ID(useR1ID), .useR2ID(useR2ID), .branchTakenEX(branchTakenEX),
        .memReqMEM(memReqMEM), .memReadyMEM(memReadyMEM),
        .pcWrite(pcWriteA), .ifidWrite(ifidWriteA), .ifidFlush(ifidFlushA),
        .idexFlush(idexFlushA), .exmemWrite(exmemWriteA), .memwbBubble(memwbBubbleA),
        .state(stateA), .memErr(memErrA)
    );

    hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(15)) dutB (
        .clk(clk), .rst(rst),
        .memReadEX(memReadEX), .rdEX(rdEX), .r1ID(r1ID), .r2ID(r2ID),
        .useR1ID(useR1ID), .useR2ID(useR2ID), .branchTakenEX(branchTakenEX),
        .memReqMEM(memReqMEM), .memReadyMEM(memReadyMEM),
        .pcWrite(pcWriteB), .ifidWrite(ifidWriteB), .ifidFlush(ifidFlushB),
        .idexFlush(idexFlushB), .exmemWrite(exmemWriteB), .memwbBubble(memwbBubbleB),
        .state(stateB), .memErr(memErrB)
    );

    // Apply one cycle of inputs just after the rising edge and queue expectations
    task automatic cyc(input logic r, input logic mrd, input logic [2:0] rd,
                       input logic [2:0] r1, input logic [2:0] r2,
                       input logic u1, input logic u2, input logic br,
                       input logic mq, input logic my,
                       input logic [1:0] sA, input logic [5:0] oA,
                       input logic [1:0] sB, input logic [5:0] oB, input logic e);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; memReadEX = mrd; rdEX = rd; r1ID = r1; r2ID = r2;
        useR1ID = u1; useR2ID = u2; branchTakenEX = br;
        memReqMEM = mq; memReadyMEM = my;
        cycNo++;
        x.stA = sA; x.oA = oA; x.stB = sB; x.oB = oB; x.err = e; x.cyc = cycNo;
        q.push_back(x);
    endtask

    task automatic idle(input logic [1:0] sA, input logic [5:0] oA,
                        input logic [1:0] sB, input logic [5:0] oB, input logic e);
        cyc(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, sA, oA, sB, oB, e);
    endtask

    // Monitor: compare both instances against the oldest expectation
    always @(negedge clk) begin
        exp_t x;
        logic [8:0] actA, actB, reqA, reqB;
        if (q.size() > 0) begin
            x = q.pop_front();
            actA = {stateA, memErrA, pcWriteA, ifidWriteA, ifidFlushA, idexFlushA, exmemWriteA, memwbBubbleA};
            actB = {stateB, memErrB, pcWriteB, ifidWriteB, ifidFlushB, idexFlushB, exmemWriteB, memwbBubbleB};
            reqA = {x.stA, x.err, x.oA};
            reqB = {x.stB, x.err, x.oB};
            compared++;
            if (actA !== reqA) begin
                mismatched++;
                $display("FAIL cyc%0d instA {state,err,pc,ifw,iff,idf,exm,mwb}: got %b want %b", x.cyc, actA, reqA);
            end
            compared++;
            if (actB !== reqB) begin
                mismatched++;
                $display("FAIL cyc%0d instB {state,err,pc,ifw,iff,idf,exm,mwb}: got %b want %b", x.cyc, actB, reqB);
            end
        end
    end

    initial begin
        // Reset held three cycles: frozen pipeline, NOPs injected
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, c_RST, 2'b00, c_RST, 1'b0);
        idle(2'b00, c_DEF, 2'b00, c_DEF, 1'b0);
        idle(2'b00, c_DEF, 2'b00, c_DEF, 1'b0);

        // Load-use on r2: A stalls 1 cycle, B stalls 3 (00->01->01->00)
        cyc(1'b1, 1'b1, 3'd3, 3'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, c_STALL, 2'b00, c_STALL, 1'b0);
        idle(2'b00, c_DEF, 2'b01, c_STALL, 1'b0);
        idle(2'b00, c_DEF, 2'b01, c_STALL, 1'b0);
        idle(2'b00, c_DEF, 2'b00, c_DEF, 1'b0);

        // rdEX=0 never hazards; register match without use flag never hazards
        cyc(1'b1, 1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, c_DEF, 2'b00, c_DEF, 1'b0);
        cyc(1'b1, 1'b1, 3'd5, 3'd5, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, c_DEF, 2'b00, c_DEF, 1'b0);
        // Load-use on r1 (A only shows 1-cycle stall; B starts its 3-cycle stall)
        cyc(1'b1, 1'b1, 3'd5, 3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, c_STALL, 2'b00, c_STALL, 1'b0);
        idle(2'b00, c_DEF, 2'b01, c_STALL, 1'b0);
        idle(2'b00, c_DEF, 2'b01, c_STALL, 1'b0);
        idle(2'b00, c_DEF, 2'b00, c_DEF, 1'b0);

        // Branch together with load-use: flush wins, no stall follows
        cyc(1'b1, 1'b1, 3'd3, 3'd0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, c_FLUSH, 2'b00, c_FLUSH, 1'b0);
        idle(2'b00, c_DEF, 2'b00, c_DEF, 1'b0);

        // Branch in the 2nd LOADSTALL cycle of B aborts the stall
        cyc(1'b1, 1'b1, 3'd3, 3'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, c_STALL, 2'b00, c_STALL, 1'b0);
        idle(2'b00, c_DEF, 2'b01, c_STALL, 1'b0);
        cyc(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, c_FLUSH, 2'b01, c_FLUSH, 1'b0);
        idle(2'b00, c_DEF, 2'b00, c_DEF, 1'b0);

        // Memory ready immediately: no wait
        cyc(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, c_DEF, 2'b00, c_DEF, 1'b0);

        // Memory wait 4 cycles then ready
        cyc(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, c_FREEZE, 2'b00, c_FREEZE, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, c_FREEZE, 2'b10, c_FREEZE, 1'b0);
        cyc(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, c_DEF, 2'b10, c_DEF, 1'b0);
        idle(2'b00, c_DEF, 2'b00, c_DEF, 1'b0);

        // Memory wait beats a simultaneous branch
        cyc(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, c_FREEZE, 2'b00, c_FREEZE, 1'b0);
        cyc(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, c_DEF, 2'b10, c_DEF, 1'b0);
        idle(2'b00, c_DEF, 2'b00, c_DEF, 1'b0);

        // Timeout: entry cycle, 14 frozen MEMWAIT cycles (branch/luh ignored), release on the 15th
        cyc(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, c_FREEZE, 2'b00, c_FREEZE, 1'b0);
        for (int i = 0; i < 14; i++) begin
            if (i == 5)
                cyc(1'b1, 1'b1, 3'd3, 3'd0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, c_FREEZE, 2'b10, c_FREEZE, 1'b0);
            else
                cyc(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, c_FREEZE, 2'b10, c_FREEZE, 1'b0);
        end
        cyc(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, c_DEF, 2'b10, c_DEF, 1'b0);
        idle(2'b00, c_DEF, 2'b00, c_DEF, 1'b1);
        idle(2'b00, c_DEF, 2'b00, c_DEF, 1'b1);
        idle(2'b00, c_DEF, 2'b00, c_DEF, 1'b1);

        // Only reset clears the sticky error
        cyc(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, c_RST, 2'b00, c_RST, 1'b0);
        idle(2'b00, c_DEF, 2'b00, c_DEF, 1'b0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
